// File: rtl/fft_fixed_pkg.sv
// Shared fixed-point formats for the 16-point FFT datapath:
// Q8.8 samples, Q2.6 twiddles and the exact Q10.14 product between them.
package fft_fixed_pkg;

  localparam int DATA_W    = 16;
  localparam int DATA_FRAC = 8;
  localparam int COEF_W    = 8;
  localparam int COEF_FRAC = 6;
  localparam int PROD_W    = DATA_W + COEF_W;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] twiddle_t;
  typedef logic signed [PROD_W-1:0] product_t;

  localparam sample_t  SAMPLE_MAX = 16'h7FFF;
  localparam sample_t  SAMPLE_MIN = 16'h8000;
  localparam twiddle_t TW_ONE     = 8'h40;

  // A rounded, clamped sample together with its saturation flag.
  typedef struct packed {
    sample_t data;
    logic    ovf;
  } sat_result_t;

endpackage : fft_fixed_pkg

// File: rtl/fx_round_sat.sv
// Round-half-up, arithmetic right shift and clamp of a wide signed value
// down to OUT_W bits, flagging when the clamp was applied.
module fx_round_sat
  import fft_fixed_pkg::*;
#(
  parameter int IN_W  = PROD_W,
  parameter int SHIFT = COEF_FRAC,
  parameter int OUT_W = DATA_W
) (
  input  logic signed [IN_W-1:0]  val_i,
  output logic signed [OUT_W-1:0] val_o,
  output logic                    ovf_o
);

  // One guard bit above the input keeps the rounding add from wrapping.
  localparam int WIDE_W = IN_W + 1;
  localparam logic signed [WIDE_W-1:0] HALF =
    {{(WIDE_W-1){1'b0}}, 1'b1} <<< (SHIFT - 1);
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [WIDE_W-1:0] biased;
  logic signed [WIDE_W-1:0] shifted;
  logic                     pos_ovf;
  logic                     neg_ovf;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    biased  = $signed({val_i[IN_W-1], val_i}) + HALF;
    shifted = biased >>> SHIFT;

    // The result fits only if every bit from OUT_W-1 upward matches the sign.
    pos_ovf = ~shifted[WIDE_W-1] &  (|shifted[WIDE_W-2:OUT_W-1]);
    neg_ovf =  shifted[WIDE_W-1] & ~(&shifted[WIDE_W-2:OUT_W-1]);

    ovf_o = pos_ovf | neg_ovf;
    if (pos_ovf) begin
      val_o = OUT_MAX;
    end else if (neg_ovf) begin
      val_o = OUT_MIN;
    end else begin
      val_o = shifted[OUT_W-1:0];
    end
  end

endmodule : fx_round_sat

// File: rtl/signed_multiplier.sv
// Two-stage Q8.8 x Q2.6 -> Q8.8 multiplier for the FFT butterfly:
// stage 1 registers the exact product, stage 2 the rounded/saturated result.
module signed_multiplier
  import fft_fixed_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] din,
  input  logic signed [COEF_W-1:0] W,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] dout,
  output logic                     ovf
);

  product_t    prod_d, prod_q;
  logic        s1_valid_q;
  sat_result_t res_d, res_q;
  logic        out_valid_q;
  sample_t     round_val;
  logic        round_ovf;

  // Data registers only load on a valid beat so idle cycles do not toggle them.
  always_comb begin
    prod_d = prod_q;
    if (in_valid) begin
      prod_d = product_t'(din) * product_t'(W);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q     <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      prod_q     <= prod_d;
      s1_valid_q <= (in_valid === 1'b1);
    end
  end

  fx_round_sat #(
    .IN_W (PROD_W),
    .SHIFT(COEF_FRAC),
    .OUT_W(DATA_W)
  ) u_round_sat (
    .val_i(prod_q),
    .val_o(round_val),
    .ovf_o(round_ovf)
  );

  always_comb begin
    res_d = res_q;
    if (s1_valid_q) begin
      res_d.data = round_val;
      res_d.ovf  = round_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      res_q       <= res_d;
      out_valid_q <= s1_valid_q;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = res_q.data;
  assign ovf       = res_q.ovf;

endmodule : signed_multiplier

// File: tb/tb_signed_multiplier.sv
// Directed bench for signed_multiplier: inputs change and outputs are sampled
// on the falling edge, so a sample issued at one falling edge appears two later.
module tb_signed_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] din;
  logic [7:0]  W;
  logic        out_valid;
  logic [15:0] dout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  signed_multiplier dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .din      (din),
    .W        (W),
    .out_valid(out_valid),
    .dout     (dout),
    .ovf      (ovf)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [7:0] w);
    in_valid = v;
    din      = d;
    W        = w;
  endtask

  task automatic chk_valid(input string tag, input logic exp_v);
    checks++;
    assert (out_valid === exp_v) else begin
      errors++;
      $error("FAIL %s out_valid: got %b expected %b", tag, out_valid, exp_v);
    end
  endtask

  task automatic chk_out(input string tag, input logic exp_v, input logic [15:0] exp_d,
                         input logic exp_o);
    chk_valid(tag, exp_v);
    checks++;
    assert (dout === exp_d) else begin
      errors++;
      $error("FAIL %s dout: got %h expected %h", tag, dout, exp_d);
    end
    checks++;
    assert (ovf === exp_o) else begin
      errors++;
      $error("FAIL %s ovf: got %b expected %b", tag, ovf, exp_o);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 16'h0000, 8'h00);
    tick();
    tick();
    chk_out("reset", 1'b0, 16'h0000, 1'b0);
    rst = 1'b0;

    // 4.0 * 1.0, checking the latency is exactly two cycles
    drive(1'b1, 16'h0400, 8'h40);
    tick();
    drive(1'b0, 16'h1234, 8'h55);
    chk_valid("lat1", 1'b0);
    tick();
    chk_out("unity", 1'b1, 16'h0400, 1'b0);
    tick();
    chk_out("hold", 1'b0, 16'h0400, 1'b0);

    // Back-to-back stream: scaling, negation, then sign cases
    drive(1'b1, 16'h0400, 8'h3F);
    tick();
    drive(1'b1, 16'h0400, 8'hC0);
    tick();
    chk_out("scale", 1'b1, 16'h03F0, 1'b0);
    drive(1'b1, 16'hFC00, 8'hC0);
    tick();
    chk_out("neg1", 1'b1, 16'hFC00, 1'b0);
    drive(1'b1, 16'hBC00, 8'hE0);
    tick();
    chk_out("negneg1", 1'b1, 16'h0400, 1'b0);
    drive(1'b1, 16'hF600, 8'hF8);
    tick();
    chk_out("negneg2", 1'b1, 16'h2200, 1'b0);
    drive(1'b1, 16'h0001, 8'h20);
    tick();
    chk_out("negneg3", 1'b1, 16'h0140, 1'b0);
    drive(1'b1, 16'hFFFF, 8'h20);
    tick();
    chk_out("rnd_up", 1'b1, 16'h0001, 1'b0);
    drive(1'b1, 16'h8000, 8'hC0);
    tick();
    chk_out("rnd_neg", 1'b1, 16'h0000, 1'b0);
    drive(1'b1, 16'h8000, 8'h40);
    tick();
    chk_out("sat_pos", 1'b1, 16'h7FFF, 1'b1);
    drive(1'b1, 16'h0000, 8'h7F);
    tick();
    chk_out("min_ok", 1'b1, 16'h8000, 1'b0);
    drive(1'b1, 16'h7FFF, 8'h00);
    tick();
    chk_out("zero_din", 1'b1, 16'h0000, 1'b0);
    drive(1'b0, 16'h0000, 8'h00);
    tick();
    chk_out("zero_w", 1'b1, 16'h0000, 1'b0);
    tick();
    chk_valid("drain", 1'b0);

    // Reset mid-stream discards both in-flight samples
    drive(1'b1, 16'h0400, 8'h40);
    tick();
    drive(1'b1, 16'h0800, 8'h40);
    tick();
    chk_out("pre_rst", 1'b1, 16'h0400, 1'b0);
    rst = 1'b1;
    drive(1'b0, 16'h0000, 8'h00);
    tick();
    chk_out("mid_rst", 1'b0, 16'h0000, 1'b0);
    rst = 1'b0;
    tick();
    chk_out("post_rst1", 1'b0, 16'h0000, 1'b0);
    tick();
    chk_out("post_rst2", 1'b0, 16'h0000, 1'b0);

    // in_valid pattern 1,0,1 reappears two cycles later
    drive(1'b1, 16'h0200, 8'h40);
    tick();
    drive(1'b0, 16'h0300, 8'h40);
    tick();
    chk_out("tog1", 1'b1, 16'h0200, 1'b0);
    drive(1'b1, 16'h0100, 8'hC0);
    tick();
    chk_valid("tog0", 1'b0);
    drive(1'b0, 16'h0000, 8'h00);
    tick();
    chk_out("tog2", 1'b1, 16'hFF00, 1'b0);
    tick();
    chk_valid("tog_end", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_signed_multiplier
